// File: rtl/ext_pkg.sv
// Shared encodings for the extension pipeline: extop mode codes and the
// occupancy states of the output/skid storage pair.
package ext_pkg;

   localparam logic [2:0] EXT_ZERO = 3'd0;
   localparam logic [2:0] EXT_SIGN = 3'd1;
   localparam logic [2:0] EXT_LUI  = 3'd2;
   localparam logic [2:0] EXT_BR   = 3'd3;
   localparam logic [2:0] EXT_LB   = 3'd4;
   localparam logic [2:0] EXT_LBU  = 3'd5;
   localparam logic [2:0] EXT_LH   = 3'd6;
   localparam logic [2:0] EXT_LHU  = 3'd7;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

endpackage

// File: rtl/ext_core.sv
// Combinational extender: immediate zero/sign/lui/branch extension and
// little-endian byte/half lane selection of load data.
module ext_core
   import ext_pkg::*;
#(
   parameter int IMM_W  = 16,
   parameter int DATA_W = 32,
   parameter int LANE_W = $clog2(DATA_W / 8)
) (
   input  logic [IMM_W-1:0]  in_imm,
   input  logic [DATA_W-1:0] in_data,
   input  logic [LANE_W-1:0] in_addr,
   input  logic [2:0]        in_extop,
   output logic [DATA_W-1:0] result,
   output logic              err
);

   localparam int NUM_B = DATA_W / 8;
   localparam int NUM_H = DATA_W / 16;

   logic [7:0]        lane_b [NUM_B];
   logic [15:0]       lane_h [NUM_H];
   logic [7:0]        sel_b;
   logic [15:0]       sel_h;
   logic [DATA_W-1:0] imm_sext;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_B; gi++) begin : g_byte
         assign lane_b[gi] = in_data[gi*8 +: 8];
      end
      for (gi = 0; gi < NUM_H; gi++) begin : g_half
         assign lane_h[gi] = in_data[gi*16 +: 16];
      end
   endgenerate

   assign sel_b    = lane_b[in_addr];
   assign sel_h    = lane_h[in_addr[LANE_W-1:1]];
   assign imm_sext = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};

   always_comb begin
      result = '0;
      err    = 1'b0;
      case (in_extop)
         EXT_ZERO: result = {{(DATA_W-IMM_W){1'b0}}, in_imm};
         EXT_SIGN: result = imm_sext;
         EXT_LUI:  result = {in_imm, {(DATA_W-IMM_W){1'b0}}};
         EXT_BR:   result = imm_sext << 2;
         EXT_LB:   result = {{(DATA_W-8){sel_b[7]}}, sel_b};
         EXT_LBU:  result = {{(DATA_W-8){1'b0}}, sel_b};
         EXT_LH, EXT_LHU: begin
            // Odd byte address cannot hold a half-word: flag it, return zero.
            if (in_addr[0]) begin
               err = 1'b1;
            end else begin
               result = {{(DATA_W-16){(in_extop == EXT_LH) & sel_h[15]}}, sel_h};
            end
         end
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/ext_pipe.sv
// Registered extension stage with a one-entry skid buffer; results are
// computed at the input and stored pre-extended in FIFO order.
module ext_pipe
   import ext_pkg::*;
#(
   parameter int IMM_W  = 16,
   parameter int DATA_W = 32,
   parameter int LANE_W = $clog2(DATA_W / 8)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IMM_W-1:0]  in_imm,
   input  logic [DATA_W-1:0] in_data,
   input  logic [LANE_W-1:0] in_addr,
   input  logic [2:0]        in_extop,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] ext_out,
   output logic              out_err
);

   state_t            state_reg;
   logic [DATA_W-1:0] out_data_reg;
   logic              out_err_reg;
   logic [DATA_W-1:0] skid_data_reg;
   logic              skid_err_reg;
   logic [DATA_W-1:0] core_result;
   logic              core_err;
   logic              accept;
   logic              drain;

   ext_core #(
      .IMM_W (IMM_W),
      .DATA_W(DATA_W),
      .LANE_W(LANE_W)
   ) u_core (
      .in_imm  (in_imm),
      .in_data (in_data),
      .in_addr (in_addr),
      .in_extop(in_extop),
      .result  (core_result),
      .err     (core_err)
   );

   // Handshake flags depend only on the state register, never on out_ready.
   assign in_ready  = (state_reg != ST_TWO);
   assign out_valid = (state_reg != ST_EMPTY);
   assign ext_out   = out_data_reg;
   assign out_err   = out_err_reg;

   assign accept = in_valid & in_ready;
   assign drain  = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_EMPTY;
         out_data_reg  <= '0;
         out_err_reg   <= 1'b0;
         skid_data_reg <= '0;
         skid_err_reg  <= 1'b0;
      end else if (flush) begin
         state_reg <= ST_EMPTY;
      end else begin
         case (state_reg)
            ST_EMPTY: begin
               if (accept) begin
                  out_data_reg <= core_result;
                  out_err_reg  <= core_err;
                  state_reg    <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && drain) begin
                  out_data_reg <= core_result;
                  out_err_reg  <= core_err;
               end else if (accept) begin
                  skid_data_reg <= core_result;
                  skid_err_reg  <= core_err;
                  state_reg     <= ST_TWO;
               end else if (drain) begin
                  state_reg <= ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (drain) begin
                  out_data_reg <= skid_data_reg;
                  out_err_reg  <= skid_err_reg;
                  state_reg    <= ST_ONE;
               end
            end
            default: state_reg <= ST_EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboard bench for ext_pipe: directed scenarios plus random traffic,
// checked against an arithmetic model of the extension rules.
module tb_ext_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_imm = '0;
   logic [31:0] in_data = '0;
   logic [1:0]  in_addr = '0;
   logic [2:0]  in_extop = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] ext_out;
   logic        out_err;

   int checks = 0;
   int passed = 0;
   int xfers  = 0;
   logic [32:0] exp_q [$];

   ext_pipe #(.IMM_W(16), .DATA_W(32), .LANE_W(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_imm   (in_imm),
      .in_data  (in_data),
      .in_addr  (in_addr),
      .in_extop (in_extop),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .ext_out  (ext_out),
      .out_err  (out_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got === want) passed++;
      else $display("FAIL %s: got %h, want %h (t=%0t)", name, got, want, $time);
   endtask

   // Reference model: plain integer arithmetic on the mode rules.
   function automatic logic [32:0] model(input logic [15:0] imm, input logic [31:0] d,
                                         input logic [1:0] a, input logic [2:0] op);
      longint v, s, b, h, r;
      logic   e;
      v = longint'(imm);
      s = (v >= 32768) ? v - 65536 : v;
      b = (longint'(d) >> (8 * int'(a))) & 255;
      h = (longint'(d) >> (16 * (int'(a) / 2))) & 65535;
      e = 1'b0;
      case (op)
         3'd0: r = v;
         3'd1: r = s;
         3'd2: r = v * 65536;
         3'd3: r = s * 4;
         3'd4: r = (b >= 128) ? b - 256 : b;
         3'd5: r = b;
         3'd6: r = (h >= 32768) ? h - 65536 : h;
         default: r = h;
      endcase
      if (op >= 3'd6 && a[0]) begin
         e = 1'b1;
         r = 0;
      end
      return {e, r[31:0]};
   endfunction

   // Monitor/scoreboard: occupancy and result checked against the expected queue.
   always @(negedge clk) begin
      int n;
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         n = exp_q.size();
         check("out_valid", 64'(out_valid), 64'(n != 0));
         check("in_ready", 64'(in_ready), 64'(n < 2));
         if (out_valid && n != 0)
            check("result", 64'({out_err, ext_out}), 64'(exp_q[0]));
         if (flush) begin
            exp_q.delete();
         end else begin
            if (n != 0 && out_ready) begin
               void'(exp_q.pop_front());
               xfers++;
               $display("xfer %0d: ext_out=%h err=%b", xfers, ext_out, out_err);
            end
            if (in_valid && n < 2)
               exp_q.push_back(model(in_imm, in_data, in_addr, in_extop));
         end
      end
   end

   task automatic rand_req();
      in_valid = 1'b1;
      in_imm   = 16'($urandom);
      in_data  = $urandom;
      in_addr  = 2'($urandom_range(0, 3));
      in_extop = 3'($urandom_range(0, 7));
   endtask

   task automatic wait_accept();
      bit ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check("accept_timeout", 64'(ok), 64'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   logic [15:0] d_imm [9];
   logic [31:0] d_data[9];
   logic [1:0]  d_addr[9];
   logic [2:0]  d_op  [9];
   logic [32:0] d_lit [9];

   initial begin
      d_imm = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h8001, 16'h0003, 16'h0, 16'h0, 16'h0, 16'h0};
      d_data = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                 32'h123480FF, 32'h123480FF, 32'h123480FF, 32'h123480FF};
      d_addr = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd1};
      d_op   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd7, 3'd6};
      d_lit  = '{{1'b0, 32'h0000FFFF}, {1'b0, 32'hFFFFFFFF}, {1'b0, 32'hFFFF0000},
                 {1'b0, 32'hFFFE0004}, {1'b0, 32'h0000000C}, {1'b0, 32'hFFFFFF80},
                 {1'b0, 32'h00000080}, {1'b0, 32'h00001234}, {1'b1, 32'h00000000}};

      // Reset values
      #12;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_ext_out", 64'(ext_out), 64'(0));
      check("rst_out_err", 64'(out_err), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk); #2;
      rst_n = 1'b1;

      // Directed modes back to back, one-cycle latency
      out_ready = 1'b1;
      for (int i = 0; i <= 9; i++) begin
         @(posedge clk); #1;
         if (i < 9) begin
            in_valid = 1'b1;
            in_imm   = d_imm[i];
            in_data  = d_data[i];
            in_addr  = d_addr[i];
            in_extop = d_op[i];
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (i > 0) begin
            check("lat_valid", 64'(out_valid), 64'(1));
            check("mode_lit", 64'({out_err, ext_out}), 64'(d_lit[i-1]));
         end
      end

      // Backpressure: third request stalls until a drain frees the skid
      @(posedge clk); #1;
      out_ready = 1'b0;
      rand_req();
      @(posedge clk); #1;
      rand_req();
      @(posedge clk); #1;
      rand_req();
      @(negedge clk);
      check("bp_in_ready_low", 64'(in_ready), 64'(0));
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_accept();
      repeat (4) @(posedge clk);

      // Flush from TWO with a request pending
      #1;
      out_ready = 1'b0;
      rand_req();
      @(posedge clk); #1;
      rand_req();
      @(posedge clk); #1;
      rand_req();
      flush = 1'b1;
      @(posedge clk); #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("flush_out_valid", 64'(out_valid), 64'(0));
      check("flush_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk); #1;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);

      // Asynchronous reset while TWO
      #1;
      out_ready = 1'b0;
      rand_req();
      @(posedge clk); #1;
      rand_req();
      @(posedge clk); #1;
      in_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", 64'(out_valid), 64'(0));
      check("arst_ext_out", 64'(ext_out), 64'(0));
      check("arst_out_err", 64'(out_err), 64'(0));
      check("arst_in_ready", 64'(in_ready), 64'(1));
      @(negedge clk);
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_imm    = 16'h1234;
      in_extop  = 3'd2;
      in_addr   = 2'd0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("post_rst_valid", 64'(out_valid), 64'(1));
      check("post_rst_lui", 64'({out_err, ext_out}), 64'({1'b0, 32'h12340000}));

      // Random traffic with occasional flushes
      for (int c = 0; c < 800; c++) begin
         @(posedge clk); #1;
         if ($urandom_range(0, 3) != 0) rand_req();
         else in_valid = 1'b0;
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 39) == 0);
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/ext_pipe.md
# ext_pipe

Parametrised, pipelined extension unit for the pipelined MIPS datapath. It covers immediate extension (zero, sign, lui, branch offset) and load-data extension (lb/lbu/lh/lhu lane select) in one block. Each request is taken through a valid/ready handshake and produced one cycle later from a registered output, backed by a one-entry skid buffer. The block sits between decode and execute for immediates, and after data memory for load results.

## Interface
- IMM_W, 16, immediate width
- DATA_W, 32, output/data width; multiple of 16, at least IMM_W+2
- LANE_W, $clog2(DATA_W/8), byte-address bits used for lane select
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous flush; discards all buffered requests
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request
- in_imm  in  IMM_W  immediate operand
- in_data  in  DATA_W  load word for byte/half modes
- in_addr  in  LANE_W  byte offset within the word
- in_extop  in  3  mode select
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- ext_out  out  DATA_W  extended result
- out_err  out  1  misaligned half-word request

## Operation
- Modes (extop):
  - 0 zero: zero-extend in_imm.
  - 1 sign: sign-extend in_imm.
  - 2 lui: {in_imm, (DATA_W-IMM_W) zeros}.
  - 3 branch: sign-extend in_imm, then shift left 2, truncated to DATA_W.
  - 4 lb: signed byte, lane in_addr.
  - 5 lbu: unsigned byte, lane in_addr.
  - 6 lh: signed half, lane in_addr[LANE_W-1:1].
  - 7 lhu: unsigned half, lane in_addr[LANE_W-1:1].
- Lanes are little-endian: lane 0 is in_data[7:0].
- Misaligned half (modes 6/7 with in_addr[0]=1): out_err=1 and ext_out=0. In every other case out_err=0.
- Extension is computed at the input. Each storage entry holds the computed result and error bit.
- Storage is an output register plus a skid register. The three states are:
  - EMPTY: output and skid both empty.
  - ONE: output full, skid empty.
  - TWO: output and skid both full.
- Transfers:
  - Accept = in_valid & in_ready.
  - Drain = out_valid & out_ready.
- State transitions:
  - EMPTY→ONE on accept.
  - ONE→EMPTY on drain without accept.
  - ONE stays ONE on drain with accept: the new result replaces the output.
  - ONE→TWO on accept without drain: the new result goes to skid.
  - TWO→ONE on drain: skid moves to the output. Accept is impossible because in_ready=0.
- Ordering is strictly FIFO. No request is lost or duplicated.
- flush has priority over everything. At the next edge the state becomes EMPTY, out_valid=0, and a request accepted in the flush cycle is dropped.

## Timing
- Reset values: out_valid=0, ext_out=0, out_err=0, in_ready=1, state EMPTY.
- Latency: an accept at edge N gives out_valid=1 with the result after edge N, when the output was empty or draining.
- in_ready = !(state==TWO). It is a register-only function with no combinational path from out_ready.
- ext_out and out_err are held stable while out_valid=1 and out_ready=0.
- Full throughput: one result per cycle when out_ready stays high.
- Reset asserted mid-operation clears both entries immediately, with no output glitch beyond the reset values.

## Structure
- Package ext_pkg holds:
  - extop localparams EXT_ZERO, EXT_SIGN, EXT_LUI, EXT_BR, EXT_LB, EXT_LBU, EXT_LH, EXT_LHU.
  - State encoding ST_EMPTY, ST_ONE, ST_TWO.
- Sub-module ext_core is the combinational extender (in_imm, in_data, in_addr, in_extop → result, err). It is instantiated once at the input.
- ext_pipe contains the handshake, the state register, and the two storage entries.

## Test plan
- Reset, then in_imm=16'hFFFF with modes 0/1/2 and out_ready=1 → ext_out is 32'h0000FFFF, 32'hFFFFFFFF, 32'hFFFF0000 on consecutive cycles, 1-cycle latency.
- Branch mode, in_imm=16'h8001 → ext_out=32'hFFFE0004. Branch mode, in_imm=16'h0003 → 32'h0000000C.
- in_data=32'h1234_80FF with lb addr=1, lbu addr=1, lhu addr=2, lh addr=1 → 32'hFFFFFF80, 32'h00000080, 32'h00001234, then out_err=1 with ext_out=0.
- out_ready=0 while issuing 3 requests → 2 accepted, in_ready=0 after the second, outputs held stable. Raise out_ready → the 2 results appear in order, in_ready returns to 1, and the third is accepted.
- State TWO, then flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, and the dropped request never appears.
- rst_n pulled low while in TWO → outputs immediately at reset values. After release, a new request completes with 1-cycle latency.
